ipd_saturado: RTL
=================

# ipd_saturado

Parametrised sequential I-PD servo controller, successor to the fixed 13-bit truncating IPD stage. On each `en` sample strobe it takes the reference `Ref` and the potentiometer reading `Pot`. It computes the incremental I-PD control law with run-time gains using a single shared multiplier, then rounds and saturates the result. It presents the new command on `salida` with a `done` pulse. It sits between the ADC sample path and the PWM generator of the servo loop.

## Interface
- `W`, 13: total width of `Ref`, `Pot`, gains and `salida`; two's complement.
- `F`, 8: fractional bits of the gains (Q(W-F).F); the data ports are integers.
- `G`, 4: guard bits on the internal accumulator.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: sample strobe; one-cycle pulse starts a computation.
- `clr` in 1: synchronous clear of the controller history; honoured only in IDLE.
- `Ref` in W: signed setpoint.
- `Pot` in W: signed measured position y[n].
- `Ki`, `Kp`, `Kd` in W each: signed gains, Q(W-F).F, sampled with `en`.
- `salida` out W: signed control output u[n]; holds its value between updates.
- `done` out 1: one-cycle pulse when `salida` updates.
- `busy` out 1: high from the cycle after `en` is accepted until `done`.
- `sat` out 1: set with `done` when u[n] was clamped; held until the next `done`.

## Operation
- Control law: u[n] = u[n-1] + Ki·e[n] − Kp·(y[n]−y[n-1]) − Kd·(y[n]−2y[n-1]+y[n-2]), where e[n] = Ref − Pot.
- History registers hold y[n-1], y[n-2] and u[n-1].
  - The stored u[n-1] is the saturated `salida`, which gives anti-windup by clamping.
  - All history resets to 0.
- FSM: IDLE → LOAD → MUL_I → MUL_P → MUL_D → SUM → IDLE.
- IDLE: `en`=1 latches `Ref`, `Pot` and the gains, then goes to LOAD. Otherwise, `clr`=1 zeroes the history and `salida`.
- LOAD: compute e (W+1 bits), d1 = y−y1 (W+1 bits) and d2 = y−2y1+y2 (W+2 bits), all sign-extended.
- MUL_I/MUL_P/MUL_D: the shared (W+2)×W signed multiplier forms one product per state.
- Each product is rounded half-up: add 2^(F−1), then arithmetic shift right by F. The result is added (I) or subtracted (P, D) into the accumulator.
  - The accumulator is W+G bits wide.
  - It is initialised with sign-extended u[n-1] in LOAD.
- SUM: clamp the accumulator to [−2^(W−1), 2^(W−1)−1].
  - Write `salida` and u[n-1] with the clamped value.
  - Set `sat` if clamped.
  - Shift history: y2←y1, y1←y.
  - Pulse `done`.
- `en` while `busy` is ignored; no queueing.
- `clr` while `busy` is ignored.
- `en` and `clr` together in IDLE: `en` wins; the computation uses the existing history.
- Reset mid-computation aborts the computation and returns to IDLE with all state zeroed.

## Timing
- Reset values: `salida`=0, `done`=0, `busy`=0, `sat`=0; FSM in IDLE.
- `en` sampled high at rising edge k:
  - `busy`=1 after edge k.
  - `salida`, `sat` updated and `done`=1 after edge k+5.
  - `busy`=0 after edge k+5.
- `done` is high for exactly one cycle.
- A new `en` is accepted at edge k+6 at the earliest, giving a throughput of one sample per 6 cycles.
- Inputs need to be stable only at the accepting edge.
- Outputs are registered; there is no combinational path from input to output.

## Test plan
- Reset/defaults (W=13, F=8): assert `rst`=0 mid-computation → all outputs 0 and FSM in IDLE; the next `en` produces a clean result.
- Integral ramp and saturation: Ki=256, Kp=Kd=0, Ref=200, Pot=0, repeated `en`:
  - `salida` = 200, 400, … 4000.
  - 21st sample gives 4095 with `sat`=1.
  - 22nd sample stays at 4095, confirming no windup.
  - Then Ref=0, Pot=200 → 3895, showing immediate recovery.
- Proportional on measurement: Kp=256, Ki=Kd=0, Pot 0→100 → `salida` = −100; Pot held at 100 → −100 unchanged.
- Derivative: Kd=256, Ki=Kp=0, Pot sequence 0, 100, 100 → `salida` = 0, −100, 0.
- Rounding: Ki=128, Ref=3, Pot=0 from clear → 2; after `clr`, Ref=−3 → −1.
- Handshake: `en` held high for 8 cycles → exactly one `done`, 5 cycles after the first edge, and a second computation starts at the following edge. `clr` pulsed while `busy` → no effect.

Source files
------------

// File: rtl/ipd_saturado.sv
// Sequential I-PD servo controller: one shared multiplier, round half-up,
// saturating output with clamp-based anti-windup.
module ipd_saturado #(
  parameter int unsigned W = 13,
  parameter int unsigned F = 8,
  parameter int unsigned G = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic signed [W-1:0] Ref,
  input  logic signed [W-1:0] Pot,
  input  logic signed [W-1:0] Ki,
  input  logic signed [W-1:0] Kp,
  input  logic signed [W-1:0] Kd,
  output logic signed [W-1:0] salida,
  output logic                done,
  output logic                busy,
  output logic                sat
);

  localparam int unsigned AW = W + G;
  localparam int unsigned EW = W + 1;
  localparam int unsigned MW = W + 2;
  localparam int unsigned PW = MW + W;

  localparam logic signed [PW-1:0] RND   = PW'(1) << (F - 1);
  localparam logic signed [AW-1:0] U_MAX = AW'((2 ** (W - 1)) - 1);
  localparam logic signed [AW-1:0] U_MIN = ~U_MAX;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MUL_I = 3'd2,
    MUL_P = 3'd3,
    MUL_D = 3'd4,
    SUM   = 3'd5
  } state_t;

  state_t state, state_n;

  logic signed [W-1:0]  ref_q, pot_q, ki_q, kp_q, kd_q;
  logic signed [W-1:0]  y1_q, y2_q, u1_q;
  logic signed [EW-1:0] e_q, d1_q;
  logic signed [MW-1:0] d2_q;
  logic signed [AW-1:0] acc_q;

  logic signed [MW-1:0] mul_a;
  logic signed [W-1:0]  mul_b;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] prod_rnd;
  logic signed [AW-1:0] term;
  logic signed [W-1:0]  clamp_val;
  logic                 clamp_hit;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state: fixed six-cycle sequence per accepted sample
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (en) state_n = LOAD;
      LOAD:    state_n = MUL_I;
      MUL_I:   state_n = MUL_P;
      MUL_P:   state_n = MUL_D;
      MUL_D:   state_n = SUM;
      SUM:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Shared multiplier operand selection
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state)
      MUL_I: begin mul_a = MW'(e_q);  mul_b = ki_q; end
      MUL_P: begin mul_a = MW'(d1_q); mul_b = kp_q; end
      MUL_D: begin mul_a = d2_q;      mul_b = kd_q; end
      default: ;
    endcase
  end

  // Product rounded half-up back to integer scale
  always_comb begin
    prod     = PW'(mul_a) * PW'(mul_b);
    prod_rnd = prod + RND;
    term     = AW'(prod_rnd >>> F);
  end

  // Output clamp to the W-bit signed range
  always_comb begin
    clamp_hit = 1'b0;
    clamp_val = acc_q[W-1:0];
    if (acc_q > U_MAX) begin
      clamp_val = U_MAX[W-1:0];
      clamp_hit = 1'b1;
    end else if (acc_q < U_MIN) begin
      clamp_val = U_MIN[W-1:0];
      clamp_hit = 1'b1;
    end
  end

  // Datapath, history and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_q  <= '0;
      pot_q  <= '0;
      ki_q   <= '0;
      kp_q   <= '0;
      kd_q   <= '0;
      y1_q   <= '0;
      y2_q   <= '0;
      u1_q   <= '0;
      e_q    <= '0;
      d1_q   <= '0;
      d2_q   <= '0;
      acc_q  <= '0;
      salida <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      sat    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en) begin
            ref_q <= Ref;
            pot_q <= Pot;
            ki_q  <= Ki;
            kp_q  <= Kp;
            kd_q  <= Kd;
            busy  <= 1'b1;
          end else if (clr) begin
            y1_q   <= '0;
            y2_q   <= '0;
            u1_q   <= '0;
            salida <= '0;
          end
        end
        LOAD: begin
          e_q   <= EW'(ref_q) - EW'(pot_q);
          d1_q  <= EW'(pot_q) - EW'(y1_q);
          d2_q  <= MW'(pot_q) - (MW'(y1_q) <<< 1) + MW'(y2_q);
          acc_q <= AW'(u1_q);
        end
        MUL_I: acc_q <= acc_q + term;
        MUL_P: acc_q <= acc_q - term;
        MUL_D: acc_q <= acc_q - term;
        SUM: begin
          salida <= clamp_val;
          u1_q   <= clamp_val;
          sat    <= clamp_hit;
          y2_q   <= y1_q;
          y1_q   <= pot_q;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
